// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt collector path.
package irq_pkg;

    localparam int N_IRQ = 8;
    localparam int IDW   = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OFFER   = 2'd1,
        SERVICE = 2'd2
    } irq_state_e;

    typedef logic [N_IRQ-1:0] irq_vec_t;

endpackage

// File: rtl/irq_edge_det.sv
// Sticky pending register fed by edge- or level-detected request lines.
module irq_edge_det #(
    parameter int N         = 8,
    parameter bit EDGE_MODE = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] i_set,
    input  logic [N-1:0] i_clr_onehot,
    output logic [N-1:0] o_pending
);

    logic [N-1:0] r_prev;
    logic [N-1:0] r_pending;
    logic [N-1:0] w_set;

    // Select the set source: rising edges or raw level.
    always_comb begin
        w_set = {N{1'b0}};
        if (EDGE_MODE) begin
            w_set = i_set & ~r_prev;
        end else begin
            w_set = i_set;
        end
    end

    // Clear is applied before set so a coincident new request is never lost.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prev    <= {N{1'b0}};
            r_pending <= {N{1'b0}};
        end else begin
            r_prev    <= i_set;
            r_pending <= (r_pending & ~i_clr_onehot) | w_set;
        end
    end

    assign o_pending = r_pending;

endmodule

// File: rtl/irq_collector.sv
// Collects 8 request lines, offers the highest-index unmasked pending id on a
// valid/ready handshake, then holds in service until end-of-interrupt.
module irq_collector
    import irq_pkg::*;
#(
    parameter bit EDGE_MODE = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic [N_IRQ-1:0] mask,
    output logic [N_IRQ-1:0] pend_o,
    output logic           req_valid,
    output logic [IDW-1:0] req_id,
    input  logic           req_ready,
    input  logic           eoi,
    output logic           in_service_o
);

    irq_state_e     r_state;
    irq_state_e     w_state_nxt;
    logic [IDW-1:0] r_req_id;
    logic [IDW-1:0] w_req_id_nxt;
    logic           r_req_valid;
    logic           r_in_service;
    logic           w_accept;
    irq_vec_t       w_clr_onehot;
    irq_vec_t       w_pending;
    irq_vec_t       w_active;

    // Highest set index wins; zero when nothing is set.
    function automatic logic [IDW-1:0] highest_idx(input irq_vec_t v);
        logic [IDW-1:0] idx;
        idx = {IDW{1'b0}};
        for (int i = 0; i < N_IRQ; i++) begin
            if (v[i]) begin
                idx = i[IDW-1:0];
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    irq_edge_det #(
        .N         (N_IRQ),
        .EDGE_MODE (EDGE_MODE)
    ) u_edge_det (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_set        (irq_in),
        .i_clr_onehot (w_clr_onehot),
        .o_pending    (w_pending)
    );

    assign w_active = w_pending & ~mask;
    assign w_accept = (r_state == OFFER) && req_ready;

    // One-hot clear of the accepted line.
    always_comb begin
        w_clr_onehot = {N_IRQ{1'b0}};
        if (w_accept) begin
            w_clr_onehot[r_req_id] = 1'b1;
        end else begin
            w_clr_onehot = {N_IRQ{1'b0}};
        end
    end

    // Next-state logic; req_id is only loaded on the IDLE->OFFER transition.
    always_comb begin
        w_state_nxt  = r_state;
        w_req_id_nxt = r_req_id;
        case (r_state)
            IDLE: begin
                if (|w_active) begin
                    w_state_nxt  = OFFER;
                    w_req_id_nxt = highest_idx(w_active);
                end else begin
                    w_state_nxt  = IDLE;
                end
            end
            OFFER: begin
                if (req_ready) begin
                    w_state_nxt = SERVICE;
                end else begin
                    w_state_nxt = OFFER;
                end
            end
            SERVICE: begin
                if (eoi) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = SERVICE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and registered Moore outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_req_id     <= {IDW{1'b0}};
            r_req_valid  <= 1'b0;
            r_in_service <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_req_id     <= w_req_id_nxt;
            r_req_valid  <= (w_state_nxt == OFFER);
            r_in_service <= (w_state_nxt == SERVICE);
        end
    end

    assign pend_o       = w_active;
    assign req_valid    = r_req_valid;
    assign req_id       = r_req_id;
    assign in_service_o = r_in_service;

endmodule

// File: tb/tb_irq_collector.sv
// Scoreboard bench for irq_collector: edge-mode instance plus a level-mode instance.
module tb_irq_collector;

    logic       clk;
    logic       rst_n;
    logic [7:0] irq_in;
    logic [7:0] mask;
    logic [7:0] pend_o;
    logic       req_valid;
    logic [2:0] req_id;
    logic       req_ready;
    logic       eoi;
    logic       in_service_o;

    logic       l_rst_n;
    logic [7:0] l_irq;
    logic [7:0] l_mask;
    logic [7:0] l_pend;
    logic       l_valid;
    logic [2:0] l_id;
    logic       l_ready;
    logic       l_eoi;
    logic       l_svc;

    int n_cmp;
    int n_err;
    logic [2:0] exp_q[$];

    irq_collector #(.EDGE_MODE(1'b1)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .irq_in       (irq_in),
        .mask         (mask),
        .pend_o       (pend_o),
        .req_valid    (req_valid),
        .req_id       (req_id),
        .req_ready    (req_ready),
        .eoi          (eoi),
        .in_service_o (in_service_o)
    );

    irq_collector #(.EDGE_MODE(1'b0)) u_lvl (
        .clk          (clk),
        .rst_n        (l_rst_n),
        .irq_in       (l_irq),
        .mask         (l_mask),
        .pend_o       (l_pend),
        .req_valid    (l_valid),
        .req_id       (l_id),
        .req_ready    (l_ready),
        .eoi          (l_eoi),
        .in_service_o (l_svc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_offer(input string tag);
        int n;
        logic [2:0] e;
        n = 0;
        while (!req_valid && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_valid"}, {31'd0, req_valid}, 32'd1);
        chk({tag, "_sb_depth"}, (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_id"}, {29'd0, req_id}, {29'd0, e});
        end
    endtask

    task automatic accept(input string tag);
        req_ready = 1'b1;
        step();
        req_ready = 1'b0;
        chk({tag, "_svc"}, {31'd0, in_service_o}, 32'd1);
        chk({tag, "_valid_lo"}, {31'd0, req_valid}, 32'd0);
    endtask

    task automatic do_eoi(input string tag);
        eoi = 1'b1;
        step();
        eoi = 1'b0;
        chk({tag, "_svc_lo"}, {31'd0, in_service_o}, 32'd0);
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rst_n = 1'b0; irq_in = 8'h00; mask = 8'h00; req_ready = 1'b0; eoi = 1'b0;
        l_rst_n = 1'b0; l_irq = 8'h00; l_mask = 8'h00; l_ready = 1'b0; l_eoi = 1'b0;
        step();
        step();
        chk("rst_pend", {24'd0, pend_o}, 32'h00);
        chk("rst_valid", {31'd0, req_valid}, 32'd0);
        chk("rst_id", {29'd0, req_id}, 32'd0);
        chk("rst_svc", {31'd0, in_service_o}, 32'd0);
        rst_n = 1'b1;
        step();

        // single edge on line 2: pending at T+1, offer at T+2
        irq_in = 8'h04;
        exp_q.push_back(3'd2);
        step();
        irq_in = 8'h00;
        chk("t1_pend", {24'd0, pend_o}, 32'h04);
        chk("t1_valid_t1", {31'd0, req_valid}, 32'd0);
        step();
        chk("t1_valid_t2", {31'd0, req_valid}, 32'd1);
        expect_offer("t1");
        accept("t1");
        chk("t1_pend_clr", {24'd0, pend_o}, 32'h00);
        do_eoi("t1");

        // two lines at once, MSB first
        irq_in = 8'h81;
        exp_q.push_back(3'd7);
        exp_q.push_back(3'd0);
        step();
        irq_in = 8'h00;
        chk("t2_pend", {24'd0, pend_o}, 32'h81);
        expect_offer("t2a");
        accept("t2a");
        chk("t2_pend_a", {24'd0, pend_o}, 32'h01);
        do_eoi("t2a");
        chk("t2_valid_e1", {31'd0, req_valid}, 32'd0);
        step();
        chk("t2_valid_e2", {31'd0, req_valid}, 32'd1);
        expect_offer("t2b");
        accept("t2b");
        chk("t2_pend_b", {24'd0, pend_o}, 32'h00);
        do_eoi("t2b");

        // masked line still latches, offered once unmasked
        mask = 8'h80;
        irq_in = 8'h88;
        exp_q.push_back(3'd3);
        step();
        irq_in = 8'h00;
        chk("t3_pend", {24'd0, pend_o}, 32'h08);
        expect_offer("t3a");
        accept("t3a");
        chk("t3_pend_m", {24'd0, pend_o}, 32'h00);
        do_eoi("t3a");
        mask = 8'h00;
        #1;
        chk("t3_pend_um", {24'd0, pend_o}, 32'h80);
        exp_q.push_back(3'd7);
        expect_offer("t3b");
        accept("t3b");
        do_eoi("t3b");

        // req_id frozen under backpressure while a higher line arrives
        irq_in = 8'h20;
        exp_q.push_back(3'd5);
        step();
        irq_in = 8'h00;
        expect_offer("t4a");
        irq_in = 8'h40;
        for (int i = 0; i < 4; i++) begin
            step();
            irq_in = 8'h00;
            chk("t4_hold_valid", {31'd0, req_valid}, 32'd1);
            chk("t4_hold_id", {29'd0, req_id}, 32'd5);
        end
        exp_q.push_back(3'd6);
        accept("t4a");
        chk("t4_pend", {24'd0, pend_o}, 32'h40);
        do_eoi("t4a");
        expect_offer("t4b");
        accept("t4b");
        do_eoi("t4b");

        // new edge on the line being accepted: set wins
        irq_in = 8'h04;
        exp_q.push_back(3'd2);
        step();
        irq_in = 8'h00;
        expect_offer("t5a");
        irq_in = 8'h04;
        exp_q.push_back(3'd2);
        accept("t5a");
        irq_in = 8'h00;
        chk("t5_pend_kept", {24'd0, pend_o}, 32'h04);
        do_eoi("t5a");
        expect_offer("t5b");
        accept("t5b");
        chk("t5_pend_clr", {24'd0, pend_o}, 32'h00);
        do_eoi("t5b");

        // reset in SERVICE discards pending; line held through reset is captured
        irq_in = 8'h01;
        exp_q.push_back(3'd0);
        step();
        irq_in = 8'h00;
        expect_offer("t6a");
        accept("t6a");
        irq_in = 8'h30;
        step();
        irq_in = 8'h00;
        chk("t6_pend", {24'd0, pend_o}, 32'h30);
        chk("t6_svc", {31'd0, in_service_o}, 32'd1);
        irq_in = 8'h08;
        rst_n = 1'b0;
        step();
        chk("t6_rst_pend", {24'd0, pend_o}, 32'h00);
        chk("t6_rst_valid", {31'd0, req_valid}, 32'd0);
        chk("t6_rst_svc", {31'd0, in_service_o}, 32'd0);
        rst_n = 1'b1;
        step();
        chk("t6_held", {24'd0, pend_o}, 32'h08);
        exp_q.push_back(3'd3);
        expect_offer("t6b");
        irq_in = 8'h00;
        accept("t6b");
        do_eoi("t6b");

        // level-sensitive instance: held line re-offered after each eoi
        l_rst_n = 1'b1;
        l_irq = 8'h02;
        step();
        step();
        chk("lv_valid_a", {31'd0, l_valid}, 32'd1);
        chk("lv_id_a", {29'd0, l_id}, 32'd1);
        l_ready = 1'b1;
        step();
        l_ready = 1'b0;
        chk("lv_svc", {31'd0, l_svc}, 32'd1);
        chk("lv_pend_held", {24'd0, l_pend}, 32'h02);
        l_eoi = 1'b1;
        step();
        l_eoi = 1'b0;
        step();
        chk("lv_valid_b", {31'd0, l_valid}, 32'd1);
        chk("lv_id_b", {29'd0, l_id}, 32'd1);
        l_irq = 8'h00;
        l_ready = 1'b1;
        step();
        l_ready = 1'b0;
        chk("lv_pend_clr", {24'd0, l_pend}, 32'h00);
        l_eoi = 1'b1;
        step();
        l_eoi = 1'b0;
        step();
        step();
        chk("lv_idle", {31'd0, l_valid}, 32'd0);

        chk("sb_leftover", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
